// File: rtl/uart_receiver.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_receiver
//
// Serial-to-parallel receiver for 8N1 UART frames. The asynchronous RxD line is
// synchronised, oversampled on an internal tick (phase accumulator), glitch
// filtered and then walked through a start / 8 data / stop bit state machine.
// Each good byte is delivered with a one-cycle strobe. Line-idle and
// end-of-packet indications are derived from a gap counter that runs while the
// receiver sits in IDLE.
//
// Parameters
//   ClkFrequency  system clock frequency in Hz
//   Baud          line bit rate
//   Oversampling  ticks per bit period (power of two, >= 4)
//
// Ports
//   clk              in   system clock, the only clock
//   rst              in   synchronous active-high reset
//   RxD              in   asynchronous serial input, idles high
//   RxD_data_ready   out  one-cycle strobe, RxD_data valid in this cycle
//   RxD_data         out  last received byte (LSB arrives first)
//   RxD_idle         out  high while no frame has started for 2*Oversampling ticks
//   RxD_endofpacket  out  one-cycle pulse when RxD_idle rises after a byte
//   RxD_frame_error  out  one-cycle pulse on a low stop bit (optional feature)
//
// Optional feature macro: UART_RX_FRAME_CHECK_EN
//   defined   : a low stop bit raises RxD_frame_error instead of
//               RxD_data_ready; RxD_data and the gap counter are left untouched.
//   undefined : RxD_frame_error is tied low and every completed frame is
//               delivered regardless of the stop-bit value.
// -----------------------------------------------------------------------------
module uart_receiver #(
    parameter int ClkFrequency = 12000000,
    parameter int Baud         = 115200,
    parameter int Oversampling = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD,
    output logic       RxD_data_ready,
    output logic [7:0] RxD_data,
    output logic       RxD_idle,
    output logic       RxD_endofpacket,
    output logic       RxD_frame_error
);

    // -------------------------------------------------------------------------
    // Derived constants
    // -------------------------------------------------------------------------
    localparam int OS_W  = $clog2(Oversampling);
    localparam int ACC_W = $clog2(ClkFrequency / (Baud * Oversampling)) + 8;
    localparam int GAP_W = OS_W + 2;

    // Accumulator increment, rounded to nearest:
    //   round(Baud * Oversampling * 2^ACC_W / ClkFrequency)
    localparam longint unsigned TICK_RATE = longint'(Baud) * longint'(Oversampling);
    localparam longint unsigned INC_L =
        ((TICK_RATE << ACC_W) + longint'(ClkFrequency / 2)) / longint'(ClkFrequency);
    localparam logic [ACC_W:0] ACC_INC = (ACC_W + 1)'(INC_L);

    localparam logic [OS_W-1:0]  PHASE_MID = OS_W'(Oversampling / 2 - 1);
    localparam logic [GAP_W-1:0] GAP_IDLE  = GAP_W'(2 * Oversampling);
    localparam logic [GAP_W-1:0] GAP_MAX   = '1;

    generate
        if (Oversampling < 4 || (Oversampling & (Oversampling - 1)) != 0) begin : g_bad_oversampling
            $error("uart_receiver: Oversampling must be a power of two and at least 4");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Receiver state machine encoding
    // -------------------------------------------------------------------------
    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_START = 4'd1,
        S_D0    = 4'd2,
        S_D1    = 4'd3,
        S_D2    = 4'd4,
        S_D3    = 4'd5,
        S_D4    = 4'd6,
        S_D5    = 4'd7,
        S_D6    = 4'd8,
        S_D7    = 4'd9,
        S_STOP  = 4'd10
    } state_t;

    state_t state_q;
    state_t state_next;

    // -------------------------------------------------------------------------
    // Tick generator
    // The carry out of the accumulator is the tick. Because the increment is
    // always below 2^ACC_W, the carry is a single-cycle pulse.
    // -------------------------------------------------------------------------
    logic [ACC_W:0] acc;
    logic           tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else begin
            acc <= {1'b0, acc[ACC_W-1:0]} + ACC_INC;
        end
    end

    assign tick = acc[ACC_W];

    // -------------------------------------------------------------------------
    // Two-flop synchroniser, reset to the idle (high) line level
    // -------------------------------------------------------------------------
    logic [1:0] rxd_sync;
    logic       synced;

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_sync <= 2'b11;
        end else begin
            rxd_sync <= {rxd_sync[0], RxD};
        end
    end

    assign synced = rxd_sync[1];

    // -------------------------------------------------------------------------
    // Glitch filter: 2-bit saturating counter with hysteresis on the output.
    // The filtered bit follows the updated count so a level change needs three
    // consistent ticks before it reaches the state machine.
    // -------------------------------------------------------------------------
    logic [1:0] filt_cnt;
    logic [1:0] filt_cnt_next;
    logic       b;

    always_comb begin
        filt_cnt_next = filt_cnt;
        if (tick) begin
            if (synced && filt_cnt != 2'd3) begin
                filt_cnt_next = filt_cnt + 2'd1;
            end else if (!synced && filt_cnt != 2'd0) begin
                filt_cnt_next = filt_cnt - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            filt_cnt <= 2'd3;
            b        <= 1'b1;
        end else begin
            filt_cnt <= filt_cnt_next;
            if (filt_cnt_next == 2'd3) begin
                b <= 1'b1;
            end else if (filt_cnt_next == 2'd0) begin
                b <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Bit-phase counter and mid-bit sample strobe
    // The counter is held at zero in IDLE, which gives the clear on the
    // IDLE->START transition; it then advances on every tick.
    // -------------------------------------------------------------------------
    logic [OS_W-1:0] phase;
    logic            sample_now;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= '0;
        end else if (state_q == S_IDLE) begin
            phase <= '0;
        end else if (tick) begin
            phase <= phase + 1'b1;
        end
    end

    assign sample_now = tick && (phase == PHASE_MID);

    // -------------------------------------------------------------------------
    // State machine: next state and control strobes
    // -------------------------------------------------------------------------
    logic armed;
    logic shift_en;
    logic complete;

    always_comb begin
        state_next = state_q;
        shift_en   = 1'b0;
        complete   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tick && !b && armed) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                if (sample_now) begin
                    // A start bit that has gone high again by mid-bit is a glitch.
                    state_next = b ? S_IDLE : S_D0;
                end
            end
            S_D0, S_D1, S_D2, S_D3, S_D4, S_D5, S_D6, S_D7: begin
                if (sample_now) begin
                    shift_en   = 1'b1;
                    state_next = (state_q == S_D7) ? S_STOP : state_t'(state_q + 4'd1);
                end
            end
            S_STOP: begin
                if (sample_now) begin
                    complete   = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Armed flag
    // Start detection is only allowed once the line has been seen high, so a
    // line held low through reset cannot fake a frame. The live synchroniser
    // output is required as well because b comes out of reset high. A low stop
    // bit (break or framing fault) disarms the receiver for the same reason:
    // the line must return high before the next start bit is believed.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            armed <= 1'b0;
        end else if (complete && !b) begin
            armed <= 1'b0;
        end else if (tick && b && synced) begin
            armed <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Data shift register: LSB arrives first, so shift right from bit 7
    // -------------------------------------------------------------------------
    logic [7:0] shift_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
        end else if (shift_en) begin
            shift_q <= {b, shift_q[7:1]};
        end
    end

    // -------------------------------------------------------------------------
    // Completion response
    // -------------------------------------------------------------------------
    logic frame_good;
    logic frame_bad;

`ifdef UART_RX_FRAME_CHECK_EN
    assign frame_good = complete && b;
    assign frame_bad  = complete && !b;
`else
    assign frame_good = complete;
    assign frame_bad  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            RxD_data_ready  <= 1'b0;
            RxD_frame_error <= 1'b0;
            RxD_data        <= 8'h00;
        end else begin
            RxD_data_ready  <= frame_good;
            RxD_frame_error <= frame_bad;
            if (frame_good) begin
                RxD_data <= shift_q;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Gap counter, idle and end-of-packet
    // Reset loads the counter saturated and marks it already full, so no
    // end-of-packet pulse appears out of reset. The counter only clears on a
    // delivered byte, so end-of-packet can only follow real traffic.
    // -------------------------------------------------------------------------
    logic [GAP_W-1:0] gap;
    logic             gap_full;
    logic             gap_full_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            gap <= GAP_MAX;
        end else if (frame_good) begin
            gap <= '0;
        end else if (tick && state_q == S_IDLE && gap != GAP_MAX) begin
            gap <= gap + 1'b1;
        end
    end

    assign gap_full = (gap >= GAP_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            gap_full_q      <= 1'b1;
            RxD_idle        <= 1'b1;
            RxD_endofpacket <= 1'b0;
        end else begin
            gap_full_q      <= gap_full;
            RxD_idle        <= gap_full && (state_q == S_IDLE);
            RxD_endofpacket <= gap_full && !gap_full_q;
        end
    end

endmodule
